fight_round_ctrl: RTL and testbench

FIGHT_ROUND_CTRL -- requirements
Module: fight_round_ctrl

---
 rtl/fight_round_ctrl_if.sv | 35 +++
 rtl/fight_round_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_fight_round_ctrl.sv | 326 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fight_round_ctrl_if.sv
// fight_round_ctrl_if
//   Bundles the fight round controller's request/grant/status signals.
//   master : player/game side that drives action requests and health.
//   slave  : fight_round_ctrl, which drives grants, latched actions,
//            reload strobe, win counters, match flags, phase and prio.
interface fight_round_ctrl_if;
  logic       actionEnable;
  logic [2:0] action1;
  logic [2:0] action2;
  logic [1:0] health1;
  logic [1:0] health2;
  logic       grant1;
  logic       grant2;
  logic [2:0] act1_q;
  logic [2:0] act2_q;
  logic       hp_reload;
  logic [1:0] wins1;
  logic [1:0] wins2;
  logic       firstWin;
  logic       secondWin;
  logic [2:0] phase;
  logic       prio;

  modport master (
    output actionEnable, action1, action2, health1, health2,
    input  grant1, grant2, act1_q, act2_q, hp_reload,
           wins1, wins2, firstWin, secondWin, phase, prio
  );

  modport slave (
    input  actionEnable, action1, action2, health1, health2,
    output grant1, grant2, act1_q, act2_q, hp_reload,
           wins1, wins2, firstWin, secondWin, phase, prio
  );
endinterface

// File: rtl/fight_round_ctrl.sv
// fight_round_ctrl
//   Sequences one action exchange per actionEnable rising edge: grants the
//   two players in prio order, checks health, credits round wins and
//   declares the match winner once a player reaches WINS_TO_MATCH.
// Ports
//   clk       : system clock, rising edge
//   resetGame : asynchronous active-low reset
//   bus       : fight_round_ctrl_if.slave (requests/health in; grants,
//               latched actions, hp_reload, wins, match flags, phase, prio out)
//
// state     | meaning
// IDLE      | waiting for an actionEnable rising edge
// GRANT_A   | grant player selected by prio (if its action is non-zero)
// GRANT_B   | grant the other player, toggle prio on exit
// CHECK     | health has settled; decide continue / round end / draw
// ROUND_END | credit the surviving player's win
// RELOAD    | one-cycle hp_reload, prio back to player 1
// MATCH_END | winner flagged, frozen until reset
module fight_round_ctrl #(
  parameter int unsigned WINS_TO_MATCH = 2
) (
  input  logic             clk,
  input  logic             resetGame,
  fight_round_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    GRANT_A   = 3'd1,
    GRANT_B   = 3'd2,
    CHECK     = 3'd3,
    ROUND_END = 3'd4,
    RELOAD    = 3'd5,
    MATCH_END = 3'd6
  } state_t;

  localparam logic [1:0] WINS_L = 2'(WINS_TO_MATCH);

  state_t     state_q, state_d;
  logic       prio_q, prio_d;
  logic [2:0] act1_q, act1_d;
  logic [2:0] act2_q, act2_d;
  logic [1:0] wins1_q, wins1_d;
  logic [1:0] wins2_q, wins2_d;
  logic       first_win_q, first_win_d;
  logic       second_win_q, second_win_d;
  logic       p1_won_q, p1_won_d;
  logic       ae_prev_q;
  logic       boot_pend_q;
  logic       boot_pulse_q;

  logic       ae_rise;
  logic       grant1, grant2, reload;
  logic [1:0] wins_new;

  // ae_prev_q resets high so an actionEnable already high at release is
  // not mistaken for a fresh edge.
  assign ae_rise = bus.actionEnable & ~ae_prev_q;

  function automatic logic [1:0] sat_inc(input logic [1:0] w);
    if (w >= WINS_L) return WINS_L;
    return w + 2'd1;
  endfunction

  always_comb begin
    state_d      = state_q;
    prio_d       = prio_q;
    act1_d       = act1_q;
    act2_d       = act2_q;
    wins1_d      = wins1_q;
    wins2_d      = wins2_q;
    first_win_d  = first_win_q;
    second_win_d = second_win_q;
    p1_won_d     = p1_won_q;
    grant1       = 1'b0;
    grant2       = 1'b0;
    reload       = 1'b0;
    wins_new     = 2'd0;

    case (state_q)
      IDLE: begin
        if (ae_rise) begin
          act1_d  = bus.action1;
          act2_d  = bus.action2;
          state_d = GRANT_A;
        end
      end
      GRANT_A: begin
        if (!prio_q) grant1 = (act1_q != 3'b000);
        else         grant2 = (act2_q != 3'b000);
        state_d = GRANT_B;
      end
      GRANT_B: begin
        if (!prio_q) grant2 = (act2_q != 3'b000);
        else         grant1 = (act1_q != 3'b000);
        prio_d  = ~prio_q;
        state_d = CHECK;
      end
      CHECK: begin
        if ((bus.health1 == 2'b00) && (bus.health2 == 2'b00)) begin
          state_d = RELOAD;
        end else if ((bus.health1 == 2'b00) || (bus.health2 == 2'b00)) begin
          // survivor is captured here; health may already be reloading later
          p1_won_d = (bus.health2 == 2'b00);
          state_d  = ROUND_END;
        end else begin
          state_d = IDLE;
        end
      end
      ROUND_END: begin
        if (p1_won_q) begin
          wins_new = sat_inc(wins1_q);
          wins1_d  = wins_new;
        end else begin
          wins_new = sat_inc(wins2_q);
          wins2_d  = wins_new;
        end
        if (wins_new == WINS_L) begin
          first_win_d  = p1_won_q;
          second_win_d = ~p1_won_q;
          state_d      = MATCH_END;
        end else begin
          state_d = RELOAD;
        end
      end
      RELOAD: begin
        reload  = 1'b1;
        prio_d  = 1'b0;
        state_d = IDLE;
      end
      MATCH_END: begin
        state_d = MATCH_END;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetGame) begin
    if (!resetGame) begin
      state_q      <= IDLE;
      prio_q       <= 1'b0;
      act1_q       <= 3'b000;
      act2_q       <= 3'b000;
      wins1_q      <= 2'd0;
      wins2_q      <= 2'd0;
      first_win_q  <= 1'b0;
      second_win_q <= 1'b0;
      p1_won_q     <= 1'b0;
      ae_prev_q    <= 1'b1;
      boot_pend_q  <= 1'b1;
      boot_pulse_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      prio_q       <= prio_d;
      act1_q       <= act1_d;
      act2_q       <= act2_d;
      wins1_q      <= wins1_d;
      wins2_q      <= wins2_d;
      first_win_q  <= first_win_d;
      second_win_q <= second_win_d;
      p1_won_q     <= p1_won_d;
      ae_prev_q    <= bus.actionEnable;
      boot_pend_q  <= 1'b0;
      boot_pulse_q <= boot_pend_q;
    end
  end

  // Grants and reload decode straight from state so an async reset kills
  // them in the same instant.
  assign bus.grant1    = grant1;
  assign bus.grant2    = grant2;
  assign bus.hp_reload = reload | boot_pulse_q;
  assign bus.act1_q    = act1_q;
  assign bus.act2_q    = act2_q;
  assign bus.wins1     = wins1_q;
  assign bus.wins2     = wins2_q;
  assign bus.firstWin  = first_win_q;
  assign bus.secondWin = second_win_q;
  assign bus.phase     = state_q;
  assign bus.prio      = prio_q;

endmodule

// File: tb/tb_fight_round_ctrl.sv
// tb_fight_round_ctrl
//   Directed scenarios plus randomized traffic, checked every cycle against
//   a timeline model: each accepted edge or health decision appends the
//   expected output snapshots of the following cycles to a queue.
module tb_fight_round_ctrl;
  localparam int W = 2;

  logic clk = 1'b0;
  logic resetGame = 1'b0;
  fight_round_ctrl_if fr();

  fight_round_ctrl #(.WINS_TO_MATCH(W)) dut (
    .clk       (clk),
    .resetGame (resetGame),
    .bus       (fr)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] ph;
    logic       g1, g2, rl;
    logic [2:0] a1, a2;
    logic       pr;
    logic [1:0] w1, w2;
    logic       fw, sw;
    logic       chk;
  } snap_t;

  int checks = 0;
  int errors = 0;

  snap_t q[$];
  snap_t base;
  logic  prev_ae;
  int    cyc;
  bit    check_en = 0;

  task automatic model_reset();
    q.delete();
    base    = '0;
    prev_ae = 1'b1;
    cyc     = 0;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // per-cycle model compare
  always @(negedge clk) begin
    snap_t cur, s, dv;
    int n;
    logic h1z, h2z;
    if (check_en) begin
      if (q.size() > 0) cur = q.pop_front();
      else begin
        cur    = base;
        cur.g1 = 1'b0;
        cur.g2 = 1'b0;
        cur.chk = 1'b0;
        cur.ph = (base.fw || base.sw) ? 3'd6 : 3'd0;
        cur.rl = (cyc == 1);
      end
      base = cur;

      dv = {fr.phase, fr.grant1, fr.grant2, fr.hp_reload, fr.act1_q, fr.act2_q,
            fr.prio, fr.wins1, fr.wins2, fr.firstWin, fr.secondWin, 1'b0};
      s = cur;
      s.chk = 1'b0;
      checks++;
      if (dv !== s) begin
        errors++;
        $display("FAIL model cyc=%0d got ph=%0d g=%b%b rl=%b a=%0d/%0d pr=%b w=%0d/%0d f=%b%b exp ph=%0d g=%b%b rl=%b a=%0d/%0d pr=%b w=%0d/%0d f=%b%b",
                 cyc, dv.ph, dv.g1, dv.g2, dv.rl, dv.a1, dv.a2, dv.pr, dv.w1, dv.w2, dv.fw, dv.sw,
                 s.ph, s.g1, s.g2, s.rl, s.a1, s.a2, s.pr, s.w1, s.w2, s.fw, s.sw);
      end
      checks++;
      if (fr.grant1 && fr.grant2) begin
        errors++;
        $display("FAIL both_grants: got 11 expected not both at cyc=%0d", cyc);
      end

      if (cur.ph == 3'd0 && fr.actionEnable && !prev_ae) begin
        s     = cur;
        s.rl  = 1'b0;
        s.chk = 1'b0;
        s.a1  = fr.action1;
        s.a2  = fr.action2;
        s.ph  = 3'd1;
        s.g1  = !cur.pr && (s.a1 != 0);
        s.g2  =  cur.pr && (s.a2 != 0);
        q.push_back(s);
        s.ph  = 3'd2;
        s.g1  =  cur.pr && (s.a1 != 0);
        s.g2  = !cur.pr && (s.a2 != 0);
        q.push_back(s);
        s.ph  = 3'd3;
        s.g1  = 1'b0;
        s.g2  = 1'b0;
        s.pr  = !cur.pr;
        s.chk = 1'b1;
        q.push_back(s);
      end

      if (cur.chk) begin
        h1z   = (fr.health1 == 2'b00);
        h2z   = (fr.health2 == 2'b00);
        s     = cur;
        s.chk = 1'b0;
        s.g1  = 1'b0;
        s.g2  = 1'b0;
        s.rl  = 1'b0;
        if (h1z && h2z) begin
          s.ph = 3'd5; s.rl = 1'b1; q.push_back(s);
          s.ph = 3'd0; s.rl = 1'b0; s.pr = 1'b0; q.push_back(s);
        end else if (h1z || h2z) begin
          s.ph = 3'd4; q.push_back(s);
          n = h2z ? int'(cur.w1) + 1 : int'(cur.w2) + 1;
          if (n > W) n = W;
          if (h2z) s.w1 = 2'(n); else s.w2 = 2'(n);
          if (n == W) begin
            s.ph = 3'd6; s.fw = h2z; s.sw = h1z; q.push_back(s);
          end else begin
            s.ph = 3'd5; s.rl = 1'b1; q.push_back(s);
            s.ph = 3'd0; s.rl = 1'b0; s.pr = 1'b0; q.push_back(s);
          end
        end
      end

      prev_ae = fr.actionEnable;
      cyc++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic samp();
    @(negedge clk);
  endtask

  task automatic fire(input logic [2:0] x1, input logic [2:0] x2);
    fr.action1      = x1;
    fr.action2      = x2;
    fr.actionEnable = 1'b1;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_phase"},  fr.phase, 0);
    chk({tag, "_prio"},   fr.prio, 0);
    chk({tag, "_grant1"}, fr.grant1, 0);
    chk({tag, "_grant2"}, fr.grant2, 0);
    chk({tag, "_reload"}, fr.hp_reload, 0);
    chk({tag, "_act1"},   fr.act1_q, 0);
    chk({tag, "_act2"},   fr.act2_q, 0);
    chk({tag, "_wins1"},  fr.wins1, 0);
    chk({tag, "_wins2"},  fr.wins2, 0);
    chk({tag, "_fwin"},   fr.firstWin, 0);
    chk({tag, "_swin"},   fr.secondWin, 0);
  endtask

  // asserts reset now, checks reset values, releases on a later cycle
  task automatic do_reset(input string tag, input logic ae_hold);
    check_en  = 0;
    resetGame = 1'b0;
    #1;
    check_reset_vals(tag);
    step();
    step();
    fr.actionEnable = ae_hold;
    fr.health1 = 2'b11;
    fr.health2 = 2'b11;
    step();
    resetGame = 1'b1;
    model_reset();
    check_en = 1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    fr.actionEnable = 1'b0;
    fr.action1 = 3'b000;
    fr.action2 = 3'b000;
    fr.health1 = 2'b11;
    fr.health2 = 2'b11;
    model_reset();

    // enable already high at release must not start an exchange
    do_reset("rst0", 1'b1);
    step(); samp();
    chk("boot_reload", fr.hp_reload, 1);
    chk("boot_phase", fr.phase, 0);
    step(); samp();
    chk("boot_reload_once", fr.hp_reload, 0);
    chk("ae_high_no_edge", fr.phase, 0);
    step(); fr.actionEnable = 1'b0;
    step();

    // arbitration
    step(); fire(3'b010, 3'b011); samp();
    chk("arb_idle", fr.phase, 0);
    step(); fr.actionEnable = 1'b0; samp();
    chk("arb_g1_first", fr.grant1, 1);
    chk("arb_g2_off", fr.grant2, 0);
    chk("arb_act1", fr.act1_q, 2);
    chk("arb_act2", fr.act2_q, 3);
    step(); samp();
    chk("arb_g2_second", fr.grant2, 1);
    chk("arb_g1_off", fr.grant1, 0);
    step(); samp();
    chk("arb_check", fr.phase, 3);
    chk("arb_prio", fr.prio, 1);
    step(); samp();
    chk("arb_idle_back", fr.phase, 0);

    // priority swap
    step(); fire(3'b010, 3'b011);
    step(); fr.actionEnable = 1'b0; samp();
    chk("swap_g2_first", fr.grant2, 1);
    chk("swap_g1_off", fr.grant1, 0);
    step(); samp();
    chk("swap_g1_second", fr.grant1, 1);
    step(); samp();
    chk("swap_prio", fr.prio, 0);
    step();

    // no-op on player 1
    step(); fire(3'b000, 3'b001);
    step(); fr.actionEnable = 1'b0; samp();
    chk("noop_g1_a", fr.grant1, 0);
    chk("noop_phase", fr.phase, 1);
    step(); samp();
    chk("noop_g2", fr.grant2, 1);
    chk("noop_g1_b", fr.grant1, 0);
    step(); samp();
    chk("noop_prio", fr.prio, 1);
    step();

    // match win for player 1
    for (int r = 1; r <= 2; r++) begin
      step(); fire(3'b010, 3'b011);
      step(); fr.actionEnable = 1'b0;
      step();
      step(); fr.health2 = 2'b00; samp();
      chk("win_check", fr.phase, 3);
      step(); fr.health2 = 2'b11; samp();
      chk("win_round_end", fr.phase, 4);
      step(); samp();
      chk("win_wins1", fr.wins1, r);
      if (r == 1) begin
        chk("win_reload", fr.hp_reload, 1);
        chk("win_phase_reload", fr.phase, 5);
        step(); samp();
        chk("win_prio_clear", fr.prio, 0);
        chk("win_idle", fr.phase, 0);
        chk("win_reload_once", fr.hp_reload, 0);
      end else begin
        chk("match_phase", fr.phase, 6);
        chk("match_fwin", fr.firstWin, 1);
        chk("match_swin", fr.secondWin, 0);
      end
    end
    for (int k = 0; k < 3; k++) begin
      step(); fire(3'b111, 3'b111);
      step(); fr.actionEnable = 1'b0; samp();
      chk("match_g1_blocked", fr.grant1, 0);
      chk("match_g2_blocked", fr.grant2, 0);
      chk("match_hold", fr.phase, 6);
    end

    // reset out of MATCH_END, then draw
    step();
    do_reset("rst_match", 1'b0);
    step(); step();
    step(); fire(3'b001, 3'b001);
    step(); fr.actionEnable = 1'b0;
    step();
    step(); fr.health1 = 2'b00; fr.health2 = 2'b00; samp();
    chk("draw_check", fr.phase, 3);
    step(); fr.health1 = 2'b11; fr.health2 = 2'b11; samp();
    chk("draw_reload", fr.hp_reload, 1);
    chk("draw_wins1", fr.wins1, 0);
    chk("draw_wins2", fr.wins2, 0);
    step(); samp();
    chk("draw_idle", fr.phase, 0);
    chk("draw_prio", fr.prio, 0);

    // reset during GRANT_A
    step(); fire(3'b100, 3'b100);
    step(); fr.actionEnable = 1'b0;
    chk("ga_grant_before_rst", fr.grant1, 1);
    do_reset("rst_ga", 1'b0);

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      step();
      if (i % 800 == 799) begin
        do_reset("rst_rand", 1'($urandom_range(0, 1)));
      end else begin
        fr.actionEnable = 1'($urandom_range(0, 1));
        fr.action1 = ($urandom_range(0, 3) == 0) ? 3'b000 : 3'($urandom_range(0, 7));
        fr.action2 = ($urandom_range(0, 3) == 0) ? 3'b000 : 3'($urandom_range(0, 7));
        fr.health1 = ($urandom_range(0, 4) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
        fr.health2 = ($urandom_range(0, 4) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
      end
    end
    step();
    samp();
    check_en = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
